// File: rtl/snake_move_ctrl_if.sv
// Bundle of the keyboard/tick inputs and the renderer-facing outputs of the
// snake movement controller. The master side drives keys and frame ticks,
// and the slave side (the controller) publishes coordinates and status.
interface snake_move_ctrl_if;
    logic       tick;
    logic       key_valid;
    logic [7:0] key_code;
    logic [5:0] Px1;
    logic [5:0] Py1;
    logic [5:0] Px2;
    logic [5:0] Py2;
    logic [5:0] Px3;
    logic [5:0] Py3;
    logic [5:0] Px4;
    logic [5:0] Py4;
    logic       AllBlack;
    logic       game_over;
    logic       busy;

    modport master (
        output tick, key_valid, key_code,
        input  Px1, Py1, Px2, Py2, Px3, Py3, Px4, Py4,
        input  AllBlack, game_over, busy
    );

    modport slave (
        input  tick, key_valid, key_code,
        output Px1, Py1, Px2, Py2, Px3, Py3, Px4, Py4,
        output AllBlack, game_over, busy
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement sequencer for the cell-indexed renderer.
// Decodes PS/2 set-2 scancodes into a pending direction and a blank-screen
// toggle, then on each frame tick shifts the four-segment body one segment
// per cycle, moves the head, checks for collisions and publishes all
// coordinates at once so the renderer never sees a half-shifted snake.
// Optional build macro WRAP_EN: when defined, the playfield edges wrap
// around and only self collision ends the game.
module snake_move_ctrl #(
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 48,
    parameter int START_X = 32,
    parameter int START_Y = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    snake_move_ctrl_if.slave   bus
);

    localparam int CW = 6;
    typedef logic [CW-1:0] coord_t;

    localparam coord_t X_MAX = coord_t'(GRID_W - 1);
    localparam coord_t Y_MAX = coord_t'(GRID_H - 1);
    localparam coord_t ZERO  = coord_t'(0);
    localparam coord_t ONE   = coord_t'(1);

`ifdef WRAP_EN
    localparam logic WRAP_WALLS = 1'b1;
`else
    localparam logic WRAP_WALLS = 1'b0;
`endif

    localparam logic [7:0] KEY_BREAK   = 8'hF0;
    localparam logic [7:0] KEY_UP      = 8'h1D;
    localparam logic [7:0] KEY_DOWN    = 8'h1B;
    localparam logic [7:0] KEY_LEFT    = 8'h1C;
    localparam logic [7:0] KEY_RIGHT   = 8'h23;
    localparam logic [7:0] KEY_ESC     = 8'h76;
    localparam logic [7:0] KEY_RESTART = 8'h29;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_S3,
        ST_S2,
        ST_S1,
        ST_HEAD,
        ST_PUB,
        ST_DEAD
    } state_e;

    // Index 0 is the head, index 3 the tail.
    coord_t segX_q [4];
    coord_t segY_q [4];
    coord_t pubX_q [4];
    coord_t pubY_q [4];

    state_e state_q;
    dir_e   dir_q;
    dir_e   pendDir_q;
    dir_e   pendDir_d;
    logic   breakSeen_q;
    logic   breakSeen_d;
    logic   allBlack_q;
    logic   allBlack_d;
    logic   gameOver_q;
    logic   busy_q;

    logic   restartKey;
    logic   keyIsDir;
    dir_e   keyDir;
    dir_e   refDir;

    coord_t headX;
    coord_t headY;
    logic   wallHit;
    logic   selfHit;
    logic   collide;

    // True when b is the exact opposite heading of a.
    function automatic logic isReverse(input dir_e a, input dir_e b);
        logic r;
        r = 1'b0;
        case (a)
            DIR_UP:    r = (b == DIR_DOWN);
            DIR_DOWN:  r = (b == DIR_UP);
            DIR_LEFT:  r = (b == DIR_RIGHT);
            DIR_RIGHT: r = (b == DIR_LEFT);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Reset column of segment i: the body trails to the left of the head.
    function automatic coord_t startX(input int i);
        return coord_t'(START_X - i);
    endfunction

    // Scancode decoder: break prefix, direction requests, blank toggle and
    // restart. During HEAD the reverse check uses the direction that is
    // being committed, so a late key can never turn the snake into its neck.
    always_comb begin
        pendDir_d   = pendDir_q;
        breakSeen_d = breakSeen_q;
        allBlack_d  = allBlack_q;
        restartKey  = 1'b0;
        keyIsDir    = 1'b0;
        keyDir      = DIR_RIGHT;
        refDir      = (state_q == ST_HEAD) ? pendDir_q : dir_q;
        if (bus.key_valid) begin
            if (breakSeen_q) begin
                breakSeen_d = 1'b0;
            end else begin
                case (bus.key_code)
                    KEY_BREAK: breakSeen_d = 1'b1;
                    KEY_UP: begin
                        keyIsDir = 1'b1;
                        keyDir   = DIR_UP;
                    end
                    KEY_DOWN: begin
                        keyIsDir = 1'b1;
                        keyDir   = DIR_DOWN;
                    end
                    KEY_LEFT: begin
                        keyIsDir = 1'b1;
                        keyDir   = DIR_LEFT;
                    end
                    KEY_RIGHT: begin
                        keyIsDir = 1'b1;
                        keyDir   = DIR_RIGHT;
                    end
                    KEY_ESC:     allBlack_d = ~allBlack_q;
                    KEY_RESTART: restartKey = 1'b1;
                    default: ;
                endcase
            end
        end
        if (keyIsDir && !isReverse(keyDir, refDir)) begin
            pendDir_d = keyDir;
        end
    end

    // Next head cell from the pending direction. Wall hits are detected from
    // the edge position and heading, and the wrapped cell is produced at the
    // same time so the wrap build just ignores the wall flag.
    always_comb begin
        headX   = segX_q[0];
        headY   = segY_q[0];
        wallHit = 1'b0;
        case (pendDir_q)
            DIR_UP: begin
                if (segY_q[0] == ZERO) begin
                    wallHit = 1'b1;
                    headY   = Y_MAX;
                end else begin
                    headY = segY_q[0] - ONE;
                end
            end
            DIR_DOWN: begin
                if (segY_q[0] == Y_MAX) begin
                    wallHit = 1'b1;
                    headY   = ZERO;
                end else begin
                    headY = segY_q[0] + ONE;
                end
            end
            DIR_LEFT: begin
                if (segX_q[0] == ZERO) begin
                    wallHit = 1'b1;
                    headX   = X_MAX;
                end else begin
                    headX = segX_q[0] - ONE;
                end
            end
            DIR_RIGHT: begin
                if (segX_q[0] == X_MAX) begin
                    wallHit = 1'b1;
                    headX   = ZERO;
                end else begin
                    headX = segX_q[0] + ONE;
                end
            end
            default: ;
        endcase
        // By HEAD the body has already shifted, so segments 1..3 hold the
        // post-shift neck-to-tail cells.
        selfHit = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (headX == segX_q[i] && headY == segY_q[i]) begin
                selfHit = 1'b1;
            end
        end
        collide = selfHit | (wallHit & ~WRAP_WALLS);
    end

    // Step sequencer: body shift one segment per cycle, head move with
    // collision check, then atomic publish; DEAD freezes until restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            dir_q       <= DIR_RIGHT;
            pendDir_q   <= DIR_RIGHT;
            breakSeen_q <= 1'b0;
            allBlack_q  <= 1'b0;
            gameOver_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                segX_q[i] <= startX(i);
                segY_q[i] <= coord_t'(START_Y);
                pubX_q[i] <= startX(i);
                pubY_q[i] <= coord_t'(START_Y);
            end
        end else begin
            breakSeen_q <= breakSeen_d;
            allBlack_q  <= allBlack_d;
            pendDir_q   <= pendDir_d;
            case (state_q)
                ST_RUN: begin
                    if (bus.tick) begin
                        state_q <= ST_S3;
                        busy_q  <= 1'b1;
                    end
                end
                ST_S3: begin
                    segX_q[3] <= segX_q[2];
                    segY_q[3] <= segY_q[2];
                    state_q   <= ST_S2;
                end
                ST_S2: begin
                    segX_q[2] <= segX_q[1];
                    segY_q[2] <= segY_q[1];
                    state_q   <= ST_S1;
                end
                ST_S1: begin
                    segX_q[1] <= segX_q[0];
                    segY_q[1] <= segY_q[0];
                    state_q   <= ST_HEAD;
                end
                ST_HEAD: begin
                    dir_q  <= pendDir_q;
                    busy_q <= 1'b0;
                    if (collide) begin
                        for (int i = 0; i < 4; i++) begin
                            segX_q[i] <= pubX_q[i];
                            segY_q[i] <= pubY_q[i];
                        end
                        gameOver_q <= 1'b1;
                        state_q    <= ST_DEAD;
                    end else begin
                        segX_q[0] <= headX;
                        segY_q[0] <= headY;
                        state_q   <= ST_PUB;
                    end
                end
                ST_PUB: begin
                    for (int i = 0; i < 4; i++) begin
                        pubX_q[i] <= segX_q[i];
                        pubY_q[i] <= segY_q[i];
                    end
                    state_q <= ST_RUN;
                end
                ST_DEAD: begin
                    if (restartKey) begin
                        for (int i = 0; i < 4; i++) begin
                            segX_q[i] <= startX(i);
                            segY_q[i] <= coord_t'(START_Y);
                            pubX_q[i] <= startX(i);
                            pubY_q[i] <= coord_t'(START_Y);
                        end
                        dir_q      <= DIR_RIGHT;
                        pendDir_q  <= DIR_RIGHT;
                        gameOver_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.Px1       = pubX_q[0];
    assign bus.Py1       = pubY_q[0];
    assign bus.Px2       = pubX_q[1];
    assign bus.Py2       = pubY_q[1];
    assign bus.Px3       = pubX_q[2];
    assign bus.Py3       = pubY_q[2];
    assign bus.Px4       = pubX_q[3];
    assign bus.Py4       = pubY_q[3];
    assign bus.AllBlack  = allBlack_q;
    assign bus.game_over = gameOver_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Testbench for snake_move_ctrl: directed scenarios followed by random key
// and tick traffic, compared against a cell-level model of the game rules.
module tb_snake_move_ctrl;

    localparam int GRID_W  = 64;
    localparam int GRID_H  = 48;
    localparam int START_X = 32;
    localparam int START_Y = 24;

`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    snake_move_ctrl_if bus ();

    snake_move_ctrl #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .START_X (START_X),
        .START_Y (START_Y)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: snake cells as plain integers, head first.
    int mX [4];
    int mY [4];
    int mDir;
    int mPend;
    bit mBreak;
    bit mBlack;
    bit mDead;

    // Headings 0..3 = UP, DOWN, LEFT, RIGHT as unit steps on the grid.
    int dxTab [4] = '{0, 0, -1, 1};
    int dyTab [4] = '{-1, 1, 0, 0};

    logic [7:0] keyTab [8] = '{8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h76, 8'h29, 8'h12};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelPlace();
        for (int i = 0; i < 4; i++) begin
            mX[i] = START_X - i;
            mY[i] = START_Y;
        end
    endtask

    task automatic modelReset();
        modelPlace();
        mDir   = 3;
        mPend  = 3;
        mBreak = 1'b0;
        mBlack = 1'b0;
        mDead  = 1'b0;
    endtask

    function automatic int codeToDir(input logic [7:0] code);
        case (code)
            8'h1D:   return 0;
            8'h1B:   return 1;
            8'h1C:   return 2;
            8'h23:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic modelKey(input logic [7:0] code);
        int nd;
        if (mBreak) begin
            mBreak = 1'b0;
        end else if (code == 8'hF0) begin
            mBreak = 1'b1;
        end else if (code == 8'h76) begin
            mBlack = !mBlack;
        end else if (code == 8'h29) begin
            if (mDead) begin
                modelPlace();
                mDir  = 3;
                mPend = 3;
                mDead = 1'b0;
            end
        end else begin
            nd = codeToDir(code);
            if (nd >= 0 && !(dxTab[nd] == -dxTab[mDir] && dyTab[nd] == -dyTab[mDir])) begin
                mPend = nd;
            end
        end
    endtask

    task automatic modelStep();
        int nx;
        int ny;
        bit wall;
        bit hit;
        if (mDead) return;
        mDir = mPend;
        nx   = mX[0] + dxTab[mDir];
        ny   = mY[0] + dyTab[mDir];
        wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
        if (WRAP) begin
            nx = (nx + GRID_W) % GRID_W;
            ny = (ny + GRID_H) % GRID_H;
        end
        // After the shift, the body occupies what were cells 0..2.
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (nx == mX[i] && ny == mY[i]) hit = 1'b1;
        end
        if (hit || (wall && !WRAP)) begin
            mDead = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) begin
                mX[i] = mX[i-1];
                mY[i] = mY[i-1];
            end
            mX[0] = nx;
            mY[0] = ny;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".Px1"}, 32'(bus.Px1), mX[0]);
        checkOutput({tag, ".Py1"}, 32'(bus.Py1), mY[0]);
        checkOutput({tag, ".Px2"}, 32'(bus.Px2), mX[1]);
        checkOutput({tag, ".Py2"}, 32'(bus.Py2), mY[1]);
        checkOutput({tag, ".Px3"}, 32'(bus.Px3), mX[2]);
        checkOutput({tag, ".Py3"}, 32'(bus.Py3), mY[2]);
        checkOutput({tag, ".Px4"}, 32'(bus.Px4), mX[3]);
        checkOutput({tag, ".Py4"}, 32'(bus.Py4), mY[3]);
        checkOutput({tag, ".AllBlack"}, 32'(bus.AllBlack), 32'(mBlack));
        checkOutput({tag, ".game_over"}, 32'(bus.game_over), 32'(mDead));
        checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        modelKey(code);
    endtask

    task automatic applyReset();
        bus.tick      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
    endtask

    // One frame tick: busy must be high for four cycles, the published
    // tail must not move before the fifth cycle, and then everything updates.
    task automatic runStep(input string tag);
        int busyCount;
        int expBusy;
        expBusy   = mDead ? 0 : 4;
        busyCount = 0;
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.busy) busyCount++;
        end
        checkOutput({tag, ".holdPx4"}, 32'(bus.Px4), mX[3]);
        checkOutput({tag, ".holdPx1"}, 32'(bus.Px1), mX[0]);
        @(negedge clk);
        modelStep();
        checkAll(tag);
        checkOutput({tag, ".busyCycles"}, busyCount, expBusy);
    endtask

    initial begin
        int k;
        bus.tick      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        modelReset();

        // Reset values and a single straight step.
        applyReset();
        checkAll("reset");
        checkOutput("reset.Px1", 32'(bus.Px1), 32);
        checkOutput("reset.Px4", 32'(bus.Px4), 29);
        runStep("step1");
        checkOutput("step1.headX", 32'(bus.Px1), 33);
        checkOutput("step1.headY", 32'(bus.Py1), 24);
        checkOutput("step1.tailX", 32'(bus.Px4), 30);

        // Turn up, then a reverse request that must be ignored.
        applyReset();
        applyStimulus(8'h1D);
        runStep("up");
        checkOutput("up.headX", 32'(bus.Px1), 32);
        checkOutput("up.headY", 32'(bus.Py1), 23);
        checkOutput("up.neckY", 32'(bus.Py2), 24);
        applyStimulus(8'h1B);
        runStep("revDown");
        checkOutput("revDown.headY", 32'(bus.Py1), 22);
        runStep("stillUp");
        checkOutput("stillUp.headY", 32'(bus.Py1), 21);

        // A make code following the break prefix is swallowed.
        applyReset();
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        runStep("brk");
        checkOutput("brk.headX", 32'(bus.Px1), 33);

        // Run to the right edge, then one more step.
        applyReset();
        repeat (31) runStep("right");
        checkOutput("edge.headX", 32'(bus.Px1), 63);
        checkOutput("edge.gameOver", 32'(bus.game_over), 0);
        runStep("wall");
`ifdef WRAP_EN
        checkOutput("wall.headX", 32'(bus.Px1), 0);
        checkOutput("wall.gameOver", 32'(bus.game_over), 0);
`else
        checkOutput("wall.headX", 32'(bus.Px1), 63);
        checkOutput("wall.gameOver", 32'(bus.game_over), 1);
`endif
        runStep("deadTick");
        applyStimulus(8'h29);
        checkAll("restart");
        checkOutput("restart.gameOver", 32'(bus.game_over), 0);

        // Tight turn sequence on the four-long snake.
        applyReset();
        applyStimulus(8'h1D);
        runStep("turnUp");
        applyStimulus(8'h1C);
        runStep("turnLeft");
        applyStimulus(8'h1B);
        runStep("turnDown");
        applyStimulus(8'h29);
        checkAll("turnRestart");

        // Escape toggles the blank-screen flag.
        applyStimulus(8'h76);
        checkOutput("black.on", 32'(bus.AllBlack), 1);
        applyStimulus(8'h76);
        checkOutput("black.off", 32'(bus.AllBlack), 0);

        // Tick held into the busy window produces exactly one step.
        runStep("preDbl");
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.tick = 1'b0;
        repeat (4) @(negedge clk);
        modelStep();
        checkAll("dblTick");
        repeat (8) @(negedge clk);
        checkAll("dblTickIdle");

        // Asynchronous reset while the body is half shifted.
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
        checkOutput("midSeq.busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("afterReset");

        // Random key and tick traffic.
        applyReset();
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                applyStimulus(keyTab[$urandom_range(0, 7)]);
            end
            if (mDead && ($urandom_range(0, 1) == 1)) begin
                applyStimulus(8'h29);
            end
            runStep("rand");
        end

        $display("[TB] random phase complete");
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
